mac_pe: RTL and testbench

Single processing element of the 3×3 systolic matrix multiplier. Each cycle it forwards its A operand east and its B operand south through one register stage. When enabled, it accumulates the product of the two operands into a local 8-bit floating-point accumulator. Nine instances form the array; each accumulator holds one element of the result matrix.

---
 rtl/mac_pe.sv | 94 +++++++++
 tb/tb_mac_pe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mac_pe.sv
// mac_pe: one systolic-array cell. Forwards A east and B south, and accumulates A*B in FP8 (1/3/4, bias 3).
// Optional build macro MAC_RNE_EN selects round-to-nearest-even instead of truncation toward zero.
module mac_pe (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   output logic [7:0] out_c
);

`ifdef MAC_RNE_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif

   // Normalise an exact magnitude into FP8. The leading one at bit position hb
   // carries unbiased-plus-bias exponent hb + adj.
   function automatic logic [7:0] fp_pack(input logic sgn, input logic [11:0] mag,
                                          input logic [5:0] adj);
      logic [3:0]        hb;
      logic [16:0]       ext;
      logic              rnd;
      logic [5:0]        mr;
      logic signed [7:0] e;
      hb = 4'd0;
      for (int i = 0; i < 12; i++)
         if (mag[i]) hb = 4'(i);
      ext = {mag, 5'b00000} << (4'd11 - hb);
      rnd = RNE & ext[11] & ((|ext[10:0]) | ext[12]);
      mr  = {1'b0, ext[16:12]} + {5'b00000, rnd};
      e   = $signed({4'b0000, hb}) + $signed({{2{adj[5]}}, adj});
      if (mr[5]) e = e + 8'sd1;
      if (mag == 12'd0)      fp_pack = 8'h00;
      else if (e > 8'sd7)    fp_pack = {sgn, 7'h7F};
      else if (e < 8'sd1)    fp_pack = 8'h00;
      else                   fp_pack = {sgn, e[2:0], mr[3:0]};
   endfunction

   // Exact fixed-point magnitude in units of 2^-6; wide enough that alignment loses nothing.
   function automatic logic [10:0] fp_fix(input logic [7:0] x);
      if (x[6:4] == 3'd0) fp_fix = 11'd0;
      else                fp_fix = {6'b000000, 1'b1, x[3:0]} << (x[6:4] - 3'd1);
   endfunction

   logic [4:0]         sig_a;
   logic [4:0]         sig_b;
   logic [9:0]         sig_p;
   logic [5:0]         prod_adj;
   logic [7:0]         prod;
   logic [10:0]        fix_c;
   logic [10:0]        fix_p;
   logic signed [12:0] term_c;
   logic signed [12:0] term_p;
   logic signed [12:0] sum;
   logic [11:0]        sum_mag;
   logic [7:0]         acc_next;

   always_comb begin
      sig_a    = {1'b1, in_a[3:0]};
      sig_b    = {1'b1, in_b[3:0]};
      sig_p    = sig_a * sig_b;
      prod_adj = {3'b000, in_a[6:4]} + {3'b000, in_b[6:4]} - 6'd11;
      if (in_a[6:4] == 3'd0 || in_b[6:4] == 3'd0)
         prod = 8'h00;
      else
         prod = fp_pack(in_a[7] ^ in_b[7], {2'b00, sig_p}, prod_adj);

      fix_c   = fp_fix(out_c);
      fix_p   = fp_fix(prod);
      term_c  = out_c[7] ? -$signed({2'b00, fix_c}) : $signed({2'b00, fix_c});
      term_p  = prod[7]  ? -$signed({2'b00, fix_p}) : $signed({2'b00, fix_p});
      sum     = term_c + term_p;
      sum_mag = sum[12] ? 12'(-sum) : sum[11:0];
      // Fixed-point LSB is 2^-6, so a leading one at bit hb has biased exponent hb-3.
      acc_next = fp_pack(sum[12], sum_mag, 6'h3D);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_a <= 8'h00;
         out_b <= 8'h00;
         out_c <= 8'h00;
      end else begin
         out_a <= in_a;
         out_b <= in_b;
         if (en) out_c <= acc_next;
      end
   end

endmodule

// File: tb/tb_mac_pe.sv
// Testbench for mac_pe: directed literal checks plus randomized traffic against a value-level FP8 model.
// Honours MAC_RNE_EN the same way the design does.
module tb_mac_pe;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic [7:0] out_c;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;
   logic [7:0] exp_a = 8'h00;
   logic [7:0] exp_b = 8'h00;
   logic [7:0] exp_c = 8'h00;

   mac_pe dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .in_a  (in_a),
      .in_b  (in_b),
      .out_a (out_a),
      .out_b (out_b),
      .out_c (out_c)
   );

   always #5 clk = ~clk;

   // Real value of an FP8 code in units of 2^-12 (exact for every code).
   function automatic int fp_val(input logic [7:0] x);
      int m;
      if (x[6:4] == 3'd0) return 0;
      m = (16 + int'(x[3:0])) << (int'(x[6:4]) + 5);
      return x[7] ? -m : m;
   endfunction

   // Round an exact value (units 2^-12) onto the FP8 grid, then saturate / flush.
   function automatic logic [7:0] to_fp8(input int v);
      int   mag, hb, e, q, m, rem;
      logic s;
      if (v == 0) return 8'h00;
      s   = (v < 0);
      mag = s ? -v : v;
      hb  = 0;
      for (int i = 0; i < 31; i++)
         if (mag >= (1 << i)) hb = i;
      if (hb < 4) return 8'h00;
      e   = hb - 9;
      q   = 1 << (hb - 4);
      m   = mag / q;
      rem = mag % q;
`ifdef MAC_RNE_EN
      if (2 * rem > q || (2 * rem == q && (m % 2) == 1)) m++;
`endif
      if (m == 32) begin
         m = 16;
         e++;
      end
      if (e > 7) return {s, 7'h7F};
      if (e < 1) return 8'h00;
      return {s, 3'(e), 4'(m - 16)};
   endfunction

   function automatic logic [7:0] model_mac(input logic [7:0] acc, input logic [7:0] a, input logic [7:0] b);
      int p;
      logic [7:0] pf;
      if (a[6:4] == 3'd0 || b[6:4] == 3'd0) p = 0;
      else begin
         p = ((16 + int'(a[3:0])) * (16 + int'(b[3:0]))) << (int'(a[6:4]) + int'(b[6:4]) - 2);
         if (a[7] ^ b[7]) p = -p;
      end
      pf = to_fp8(p);
      return to_fp8(fp_val(acc) + fp_val(pf));
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, req);
      end
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         exp_a <= 8'h00;
         exp_b <= 8'h00;
         exp_c <= 8'h00;
      end else begin
         exp_a <= in_a;
         exp_b <= in_b;
         if (en) exp_c <= model_mac(exp_c, in_a, in_b);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("out_a", out_a, exp_a);
         chk("out_b", out_b, exp_b);
         chk("out_c", out_c, exp_c);
      end
   end

   task automatic apply(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
      reset = r;
      en    = e;
      in_a  = a;
      in_b  = b;
      @(posedge clk);
      #1;
   endtask

   // Literal expectation on the accumulator: pins both the DUT and the model.
   task automatic lit(input string nm, input logic [7:0] req);
      chk({nm, "_dut"}, out_c, req);
      chk({nm, "_model"}, exp_c, req);
      $display("lit %s: a=%02h b=%02h -> out_c=%02h (expect %02h)", nm, in_a, in_b, out_c, req);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rr, re;

      apply(1'b0, 1'b1, 8'h5A, 8'h33);
      apply(1'b0, 1'b1, 8'h5A, 8'h33);
      chk("reset_a", out_a, 8'h00);
      chk("reset_b", out_b, 8'h00);
      lit("reset_c", 8'h00);
      chk_on = 1'b1;

      apply(1'b1, 1'b0, 8'h5A, 8'hC3);
      chk("pass_a", out_a, 8'h5A);
      chk("pass_b", out_b, 8'hC3);
      lit("pass_c", 8'h00);

      apply(1'b1, 1'b1, 8'h30, 8'h40);  lit("acc_2p0", 8'h40);
      apply(1'b1, 1'b1, 8'h38, 8'h40);  lit("acc_5p0", 8'h54);
      apply(1'b1, 1'b0, 8'h30, 8'h30);  lit("acc_hold", 8'h54);
      apply(1'b0, 1'b1, 8'h30, 8'h40);  lit("mid_reset", 8'h00);

      apply(1'b1, 1'b1, 8'h30, 8'h40);  lit("cancel_pre", 8'h40);
      apply(1'b1, 1'b1, 8'hB0, 8'h40);  lit("cancel", 8'h00);
      apply(1'b1, 1'b1, 8'h00, 8'h7F);  lit("zero_op", 8'h00);

      apply(1'b1, 1'b1, 8'h7F, 8'h7F);  lit("sat_pos", 8'h7F);
      apply(1'b0, 1'b0, 8'h00, 8'h00);
      apply(1'b1, 1'b1, 8'hFF, 8'h7F);  lit("sat_neg", 8'hFF);
      apply(1'b0, 1'b0, 8'h00, 8'h00);
      apply(1'b1, 1'b1, 8'h10, 8'h10);  lit("underflow", 8'h00);

      apply(1'b1, 1'b1, 8'h33, 8'h33);
`ifdef MAC_RNE_EN
      lit("round_mul", 8'h37);
`else
      lit("round_mul", 8'h36);
`endif
      apply(1'b0, 1'b0, 8'h00, 8'h00);
      apply(1'b1, 1'b1, 8'h30, 8'h40);
      apply(1'b1, 1'b1, 8'h30, 8'h91);
`ifdef MAC_RNE_EN
      lit("round_sub", 8'h3C);
`else
      lit("round_sub", 8'h3B);
`endif

      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 60) != 0);
         re = ($urandom_range(0, 3) != 0);
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            ra[6:4] = 3'($urandom_range(1, 4));
            rb[6:4] = 3'($urandom_range(1, 4));
         end
         apply(rr, re, ra, rb);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
